zm_u2_conv_pipe: RTL and testbench

- Parametrised, pipelined, bidirectional converter between sign-magnitude (ZM) and two's-complement (U2).
- Successor to the combinational ZM->U2 converter. Adds:
  - a runtime direction select;
  - a valid/ready stream handshake with backpressure;
  - a fixed 2-cycle latency;
  - a per-word error flag plus a saturating error counter.
- Sits between the operand bus and the synchronous arithmetic unit.

---
 rtl/zm_u2_conv_pipe_if.sv | 28 ++
 rtl/zm_u2_conv_pipe.sv | 104 ++++++++++
 tb/tb_zm_u2_conv_pipe.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/zm_u2_conv_pipe_if.sv
// Stream bundle for the ZM/U2 converter: input word, output word, error counter.
// No logic of its own; carries the handshake between producer, converter and consumer.
// The slave modport is the converter's side; the master modport is the surrounding logic.
interface zm_u2_conv_pipe_if #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
) ();
  logic                i_valid;
  logic                o_ready;
  logic                i_mode;
  logic [BITS-1:0]     i_arg_A;
  logic                o_valid;
  logic                i_ready;
  logic [BITS-1:0]     o_result;
  logic                o_error;
  logic [CNT_BITS-1:0] o_err_cnt;
  logic                i_clr_cnt;

  modport slave (
    input  i_valid, i_mode, i_arg_A, i_ready, i_clr_cnt,
    output o_ready, o_valid, o_result, o_error, o_err_cnt
  );

  modport master (
    output i_valid, i_mode, i_arg_A, i_ready, i_clr_cnt,
    input  o_ready, o_valid, o_result, o_error, o_err_cnt
  );
endinterface

// File: rtl/zm_u2_conv_pipe.sv
// Pipelined bidirectional sign-magnitude <-> two's-complement converter with error count.
// Latency: 2 cycles (a word accepted at edge N is presented after edge N+1).
// Backpressure: the whole pipe stalls while the output is held; o_ready = !o_valid || i_ready.
module zm_u2_conv_pipe #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  zm_u2_conv_pipe_if.slave      bus
);

  localparam logic [BITS-1:0]     ONE_W   = BITS'(1);
  localparam logic [CNT_BITS-1:0] ONE_C   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  // Stage 1: captured operand and direction.
  logic            s1_vld_q;
  logic            s1_mode_q;
  logic [BITS-1:0] s1_arg_q;

  // Stage 2: converted word presented on the output.
  logic                o_valid_q;
  logic                o_error_q;
  logic [BITS-1:0]     o_result_q;
  logic [CNT_BITS-1:0] err_cnt_q;

  logic            adv;
  logic [BITS-1:0] res_d;
  logic            err_d;
  logic [BITS-2:0] mag;
  logic [BITS-1:0] neg;

  // Both stages move together: only a held, full output stage can stall the pipe.
  assign adv = !o_valid_q || bus.i_ready;

  assign bus.o_ready   = adv;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_result  = o_result_q;
  assign bus.o_error   = o_error_q;
  assign bus.o_err_cnt = err_cnt_q;

  assign mag = s1_arg_q[BITS-2:0];
  assign neg = ~s1_arg_q + ONE_W;

  // Conversion of the stage-1 word; a sign bit with zero magnitude is the error case in both
  // directions (negative zero for ZM, -2^(BITS-1) for U2) and yields 0.
  always_comb begin
    res_d = s1_arg_q;
    err_d = 1'b0;
    if (s1_arg_q[BITS-1]) begin
      if (mag == '0) begin
        res_d = '0;
        err_d = 1'b1;
      end else if (!s1_mode_q) begin
        res_d = ~{1'b0, mag} + ONE_W;
      end else begin
        res_d = {1'b1, neg[BITS-2:0]};
      end
    end
  end

  // Stage 1 capture; operand registers only load on a real input word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_arg_q  <= '0;
    end else if (adv) begin
      s1_vld_q <= bus.i_valid;
      if (bus.i_valid) begin
        s1_mode_q <= bus.i_mode;
        s1_arg_q  <= bus.i_arg_A;
      end
    end
  end

  // Stage 2 output register; data holds through bubbles so the outputs stay quiet.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_q  <= 1'b0;
      o_result_q <= '0;
      o_error_q  <= 1'b0;
    end else if (adv) begin
      o_valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        o_result_q <= res_d;
        o_error_q  <= err_d;
      end
    end
  end

  // Saturating count of delivered error words; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_q <= '0;
    end else if (bus.i_clr_cnt) begin
      err_cnt_q <= '0;
    end else if (o_valid_q && bus.i_ready && o_error_q && (err_cnt_q != CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + ONE_C;
    end
  end

endmodule

// File: tb/tb_zm_u2_conv_pipe.sv
// Directed bench for zm_u2_conv_pipe with BITS=8, CNT_BITS=2.
// Inputs change 1 time unit after the rising edge; outputs are read there or at the falling edge.
// A falling-edge monitor records every output transfer for order/loss/duplication checks.
module tb_zm_u2_conv_pipe;
  localparam int BITS     = 8;
  localparam int CNT_BITS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zm_u2_conv_pipe_if #(.BITS(BITS), .CNT_BITS(CNT_BITS)) bus ();

  zm_u2_conv_pipe #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [8:0] q[$];        // {error, result} of each output transfer
  logic [7:0] u2_of[256];

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) q.push_back({bus.o_error, bus.o_result});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  // Present a word and hold it until it is taken at a rising edge.
  task automatic send(input logic m, input logic [7:0] a);
    int waited = 0;
    bus.i_valid = 1'b1;
    bus.i_mode  = m;
    bus.i_arg_A = a;
    @(negedge clk);
    while (!bus.o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    int w = 0;
    while (q.size() < n && w < 300) begin
      step();
      w++;
    end
    chk("drain_count", (q.size() >= n), 1);
  endtask

  task automatic chk_pop(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    got = 9'h1FF;
    if (q.size() > 0) got = q.pop_front();
    chk(tag, got, exp);
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_valid   = 1'b0;
    bus.i_mode    = 1'b0;
    bus.i_arg_A   = '0;
    bus.i_ready   = 1'b1;
    bus.i_clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_ready", bus.o_ready, 1);
    chk("rst_o_result", bus.o_result, 8'h00);
    chk("rst_o_error", bus.o_error, 0);
    chk("rst_err_cnt", bus.o_err_cnt, 0);

    // ZM->U2 stream, one word per cycle, 2-cycle latency
    send(1'b0, 8'h05);
    chk("t1_lat_valid0", bus.o_valid, 0);
    send(1'b0, 8'h85);
    chk("t1_w0_valid", bus.o_valid, 1);
    chk("t1_w0", {bus.o_error, bus.o_result}, {1'b0, 8'h05});
    send(1'b0, 8'hFF);
    chk("t1_w1", {bus.o_valid, bus.o_error, bus.o_result}, {2'b10, 8'hFB});
    send(1'b0, 8'h7F);
    chk("t1_w2", {bus.o_valid, bus.o_error, bus.o_result}, {2'b10, 8'h81});
    idle();
    step();
    chk("t1_w3", {bus.o_valid, bus.o_error, bus.o_result}, {2'b10, 8'h7F});
    step();
    chk("t1_bubble_valid", bus.o_valid, 0);
    chk("t1_err_cnt", bus.o_err_cnt, 0);

    // Error words in both directions
    q.delete();
    send(1'b0, 8'h80);
    send(1'b1, 8'h80);
    idle();
    repeat (3) step();
    drain(2);
    chk_pop("t2_zm_negzero", {1'b1, 8'h00});
    chk_pop("t2_u2_min", {1'b1, 8'h00});
    chk("t2_err_cnt", bus.o_err_cnt, 2);
    bus.i_clr_cnt = 1'b1;
    step();
    bus.i_clr_cnt = 1'b0;
    chk("t2_clr", bus.o_err_cnt, 0);

    // U2->ZM vectors
    q.delete();
    send(1'b1, 8'hFB);
    send(1'b1, 8'h81);
    send(1'b1, 8'h05);
    idle();
    drain(3);
    chk_pop("t3_FB", {1'b0, 8'h85});
    chk_pop("t3_81", {1'b0, 8'hFF});
    chk_pop("t3_05", {1'b0, 8'h05});

    // Round trip over every non-error ZM code
    q.delete();
    for (int z = 0; z < 256; z++) if (z != 8'h80) send(1'b0, 8'(z));
    idle();
    drain(255);
    for (int z = 0; z < 256; z++) begin
      if (z != 8'h80) begin
        logic [8:0] e;
        e = 9'h1FF;
        if (q.size() > 0) e = q.pop_front();
        u2_of[z] = e[7:0];
        if (e[8]) chk("rt_fwd_err", e, {1'b0, e[7:0]});
      end
    end
    q.delete();
    for (int z = 0; z < 256; z++) if (z != 8'h80) send(1'b1, u2_of[z]);
    idle();
    drain(255);
    for (int z = 0; z < 256; z++) if (z != 8'h80) chk_pop("rt_back", {1'b0, 8'(z)});
    chk("rt_err_cnt", bus.o_err_cnt, 0);

    // Backpressure: stall 5 cycles after the first output
    q.delete();
    send(1'b0, 8'h01);
    send(1'b0, 8'h82);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_mode  = 1'b0;
    bus.i_arg_A = 8'h03;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", bus.o_valid, 1);
      chk("bp_hold_result", bus.o_result, 8'h01);
      chk("bp_o_ready", bus.o_ready, 0);
    end
    bus.i_ready = 1'b1;
    send(1'b0, 8'h03);
    send(1'b0, 8'h84);
    idle();
    drain(4);
    repeat (3) step();
    chk("bp_count", q.size(), 4);
    chk_pop("bp_w0", {1'b0, 8'h01});
    chk_pop("bp_w1", {1'b0, 8'hFE});
    chk_pop("bp_w2", {1'b0, 8'h03});
    chk_pop("bp_w3", {1'b0, 8'hFC});

    // Saturating counter with CNT_BITS=2
    for (int k = 0; k < 5; k++) begin
      send(1'b0, 8'h80);
      idle();
      step();
      step();
      chk($sformatf("sat_cnt_%0d", k), bus.o_err_cnt, (k < 3) ? k + 1 : 3);
    end
    send(1'b0, 8'h80);
    idle();
    step();
    chk("clr_pending_err", {bus.o_valid, bus.o_error}, 2'b11);
    bus.i_clr_cnt = 1'b1;
    step();
    bus.i_clr_cnt = 1'b0;
    chk("clr_wins_cnt", bus.o_err_cnt, 0);
    chk("clr_transfer_done", bus.o_valid, 0);

    // Reset with both stages full and output stalled
    send(1'b0, 8'h80);
    idle();
    step();
    step();
    chk("pre_rst_cnt", bus.o_err_cnt, 1);
    q.delete();
    bus.i_ready = 1'b0;
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    idle();
    chk("full_o_ready", bus.o_ready, 0);
    chk("full_o_result", {bus.o_valid, bus.o_result}, {1'b1, 8'h11});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_o_valid", bus.o_valid, 0);
    chk("rst2_err_cnt", bus.o_err_cnt, 0);
    chk("rst2_o_ready", bus.o_ready, 1);
    chk("rst2_o_result", {bus.o_error, bus.o_result}, 9'h000);
    bus.i_ready = 1'b1;
    repeat (5) step();
    chk("rst2_flushed", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
